// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped console transmitter.
package uart_tx_pkg;

  // Register offsets within the two-word window
  localparam logic [31:0] OFS_STATUS = 32'd0;
  localparam logic [31:0] OFS_DATA   = 32'd4;

  // Status word bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  // Serial transmitter states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// Synchronous FIFO with occupancy count; push into a full FIFO and pop from
// an empty FIFO are ignored. The read port is combinational from the head.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, data only, never reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Console transmitter on the data-RAM bus: status word at BASE, TX data at
// BASE+4. Written bytes are queued and sent 8N1, LSB first, on uart_txd.
module uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'hE000_0000,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_cen,
  input  logic        ram_wen,
  input  logic [3:0]  ram_flag,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic        uart_txd,
  output logic        tx_done_irq
);

  import uart_tx_pkg::*;

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int                BAUD_W    = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_DIV - 1);

  logic             hit0;
  logic             hit4;
  logic             push_req;
  logic             ovf_set;
  logic             ovf_clr;
  logic             ovf_q;
  logic [31:0]      status;

  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  tx_state_t        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             irq_q, irq_d;

  // Bits of the bus word that no register uses
  logic             unused_bus;
  assign unused_bus = ^{ram_wdata[31:8], ram_flag[3:1]};

  assign hit0     = (ram_addr == BASE_ADDR + OFS_STATUS);
  assign hit4     = (ram_addr == BASE_ADDR + OFS_DATA);
  assign push_req = ram_cen && ram_wen && hit4 && ram_flag[0];
  // A same-cycle pop never makes room for a push into a full FIFO
  assign ovf_set  = push_req && fifo_full;
  assign ovf_clr  = ram_cen && ram_wen && hit0 && ram_flag[0] && ram_wdata[2];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (ram_wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Status word assembled from the state before the current edge
  always_comb begin
    status                    = '0;
    status[ST_FULL]           = fifo_full;
    status[ST_BUSY]           = (state_q != IDLE) || !fifo_empty;
    status[ST_OVF]            = ovf_q;
    status[ST_CNT_LSB +: 8]   = 8'(fifo_count);
  end

  // Sticky overflow flag; a simultaneous overflow beats the clear
  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  // Registered read data; only hit reads update it
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rdata <= '0;
    end else if (ram_cen && !ram_wen) begin
      if (hit0)      ram_rdata <= status;
      else if (hit4) ram_rdata <= '0;
    end
  end

  // Transmitter next-state, bit timing and output bit selection
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    fifo_pop  = 1'b0;
    irq_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          baud_d   = BAUD_LOAD;
          state_d  = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d    = BAUD_LOAD;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            baud_d   = BAUD_LOAD;
            state_d  = START;
          end else begin
            irq_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The line level follows the state being entered so uart_txd is a flop
    txd_d = (state_d == DATA) ? shreg_d[0] : (state_d != START);
  end

  // Transmitter control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
    end
  end

  // Shift register holds frame data only and needs no reset
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign uart_txd    = txd_q;
  assign tx_done_irq = irq_q;

endmodule
